// File: rtl/nitc_mem_pkg.sv
// Shared types and constants for the NITC-RISC24 memory responder.
//   state_e    : responder FSM states
//   region_e   : address-decode result
//   core_req_t : core request captured when a transaction starts
package nitc_mem_pkg;

  localparam int unsigned DATA_BITS = 16;

  localparam logic [15:0] OUT_PORT_ADR  = 16'hFFFE;
  localparam logic [15:0] CYCLE_CNT_ADR = 16'hFFFC;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_OUT,
    RGN_CNT,
    RGN_NONE
  } region_e;

  typedef struct packed {
    logic [15:0] adr;
    logic [15:0] wdata;
    logic        is_wr;
  } core_req_t;

  // Word addresses below 2^addr_bits hit RAM; two fixed MMIO words; rest unmapped.
  function automatic region_e decode_adr(input logic [15:0] adr, input int unsigned addr_bits);
    region_e rgn;
    if (32'(adr) < (32'd1 << addr_bits)) rgn = RGN_RAM;
    else if (adr == OUT_PORT_ADR)        rgn = RGN_OUT;
    else if (adr == CYCLE_CNT_ADR)       rgn = RGN_CNT;
    else                                 rgn = RGN_NONE;
    return rgn;
  endfunction

endpackage

// File: rtl/nitc_mem_responder_if.sv
// Core + loader bus of the memory responder.
//   master : core / loader side (drives requests, receives responses)
//   slave  : responder side
interface nitc_mem_responder_if #(
  parameter int unsigned ADDR_BITS = 8
) ();

  logic [15:0]          adr;
  logic [15:0]          writedata;
  logic                 memwrite;
  logic                 memread;
  logic [15:0]          readdata;
  logic                 ready;
  logic                 ld_valid;
  logic [ADDR_BITS-1:0] ld_adr;
  logic [15:0]          ld_data;
  logic                 ld_ready;
  logic [15:0]          out_port;

  modport master (
    output adr, writedata, memwrite, memread, ld_valid, ld_adr, ld_data,
    input  readdata, ready, ld_ready, out_port
  );

  modport slave (
    input  adr, writedata, memwrite, memread, ld_valid, ld_adr, ld_data,
    output readdata, ready, ld_ready, out_port
  );

endinterface

// File: rtl/nitc_ram_sp.sv
// Single-port synchronous RAM with registered read; contents are not reset.
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : read data, registered (old data on read-during-write)
module nitc_ram_sp #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/nitc_mem_responder.sv
// Memory-side responder for the NITC-RISC24 core: word RAM, out_port and
// cycle-counter MMIO, wait-state insertion and a low-priority loader port.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : core request/response and loader signals (slave side)
module nitc_mem_responder
  import nitc_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  nitc_mem_responder_if.slave  bus
);

  localparam int unsigned WCNT_BITS = 4;

  state_e               state_q, state_d;
  logic [WCNT_BITS-1:0] wcnt_q, wcnt_d;
  core_req_t            req_q, cur_req;
  region_e              cur_rgn;
  logic [15:0]          cnt_q, cnt_lat_q, readdata_q, out_port_q;
  logic                 ready_q, ld_ready_q;
  logic                 core_req_c, start_c, ld_take_c, enter_resp_c;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [15:0]          ram_wdata, ram_rdata;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // FSM next state; core request beats loader in IDLE
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    start_c   = 1'b0;
    ld_take_c = 1'b0;
    // A request still visible during the ready cycle is the one just acknowledged.
    core_req_c = (bus.memread | bus.memwrite) & ~ready_q;
    case (state_q)
      IDLE: begin
        if (core_req_c) begin
          start_c = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            wcnt_d  = WCNT_BITS'(WAIT_STATES - 1);
          end
        end else if (bus.ld_valid) begin
          ld_take_c = 1'b1;
        end
      end
      WAIT: begin
        if (wcnt_q == '0) state_d = RESP;
        else              wcnt_d  = wcnt_q - WCNT_BITS'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Live inputs in IDLE, captured request afterwards; RAM port mux
  always_comb begin
    cur_req = req_q;
    if (state_q == IDLE) begin
      cur_req.adr   = bus.adr;
      cur_req.wdata = bus.writedata;
      cur_req.is_wr = bus.memwrite;
    end
    cur_rgn      = decode_adr(cur_req.adr, ADDR_BITS);
    enter_resp_c = (state_d == RESP);
    // Reset gating keeps a write from committing on a reset edge.
    ram_we    = reset & (ld_take_c | (enter_resp_c & cur_req.is_wr & (cur_rgn == RGN_RAM)));
    ram_addr  = ld_take_c ? bus.ld_adr  : cur_req.adr[ADDR_BITS-1:0];
    ram_wdata = ld_take_c ? bus.ld_data : cur_req.wdata;
  end

  nitc_ram_sp #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Request capture, MMIO, counter and registered responses
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_q      <= '0;
      cnt_q      <= '0;
      cnt_lat_q  <= '0;
      readdata_q <= '0;
      out_port_q <= '0;
      ready_q    <= 1'b0;
      ld_ready_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_q + 16'd1;
      ready_q    <= (state_q == RESP);
      ld_ready_q <= ld_take_c;
      if (start_c) begin
        req_q     <= cur_req;
        cnt_lat_q <= cnt_q;
      end
      if (enter_resp_c && cur_req.is_wr && (cur_rgn == RGN_OUT)) out_port_q <= cur_req.wdata;
      // RAM data was read at the edge entering RESP
      if ((state_q == RESP) && !req_q.is_wr) begin
        case (cur_rgn)
          RGN_RAM: readdata_q <= ram_rdata;
          RGN_OUT: readdata_q <= out_port_q;
          RGN_CNT: readdata_q <= cnt_lat_q;
          default: readdata_q <= '0;
        endcase
      end
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.ready    = ready_q;
  assign bus.ld_ready = ld_ready_q;
  assign bus.out_port = out_port_q;

endmodule

// File: tb/tb_nitc_mem_responder.sv
// Self-checking bench: one responder with WAIT_STATES=1 (index 0) and one with
// WAIT_STATES=0 (index 1), checked against a word-level memory/MMIO model.
module tb_nitc_mem_responder;

  logic clk, reset;
  int   checks, errors;
  logic [15:0] cyc;

  logic [15:0] t_adr[2], t_wd[2], t_ldd[2];
  logic        t_mr[2], t_mw[2], t_ldv[2];
  logic [7:0]  t_lda[2];
  logic        o_ready[2], o_ldr[2];
  logic [15:0] o_rdata[2], o_out[2];

  logic [15:0] ref_mem[2][256];
  logic [15:0] ref_out[2], ref_rd[2];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] adr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    logic [15:0] exp_out;
  } vec_t;
  vec_t tbl[12];

  nitc_mem_responder_if #(.ADDR_BITS(8)) bus0 ();
  nitc_mem_responder_if #(.ADDR_BITS(8)) bus1 ();

  nitc_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(1)) dut_ws1 (.clk(clk), .reset(reset), .bus(bus0));
  nitc_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) dut_ws0 (.clk(clk), .reset(reset), .bus(bus1));

  assign bus0.adr = t_adr[0];      assign bus1.adr = t_adr[1];
  assign bus0.writedata = t_wd[0]; assign bus1.writedata = t_wd[1];
  assign bus0.memread = t_mr[0];   assign bus1.memread = t_mr[1];
  assign bus0.memwrite = t_mw[0];  assign bus1.memwrite = t_mw[1];
  assign bus0.ld_valid = t_ldv[0]; assign bus1.ld_valid = t_ldv[1];
  assign bus0.ld_adr = t_lda[0];   assign bus1.ld_adr = t_lda[1];
  assign bus0.ld_data = t_ldd[0];  assign bus1.ld_data = t_ldd[1];
  assign o_ready[0] = bus0.ready;    assign o_ready[1] = bus1.ready;
  assign o_ldr[0] = bus0.ld_ready;   assign o_ldr[1] = bus1.ld_ready;
  assign o_rdata[0] = bus0.readdata; assign o_rdata[1] = bus1.readdata;
  assign o_out[0] = bus0.out_port;   assign o_out[1] = bus1.out_port;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles elapsed since reset release (the counter the DUT should expose)
  always @(posedge clk) cyc <= !reset ? 16'd0 : cyc + 16'd1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One core transaction; checks latency, single pulse, readdata and out_port against the model.
  task automatic core_txn(input int k, input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, input string tag, input bit skip_sync,
                          output logic [15:0] got_rd, output logic [15:0] got_out);
    int ws, first, hits;
    logic rel;
    logic [15:0] cnt_snap, exp_rd;
    ws = (k == 0) ? 1 : 0;
    if (!skip_sync) @(negedge clk);
    t_adr[k] = a; t_wd[k] = wd; t_mr[k] = rd; t_mw[k] = wr;
    cnt_snap = cyc;
    first = 0; hits = 0; rel = 1'b0; got_rd = '0; got_out = '0;
    for (int c = 1; c <= ws + 5; c++) begin
      @(negedge clk);
      if (rel) begin t_mr[k] = 1'b0; t_mw[k] = 1'b0; rel = 1'b0; end
      if (o_ready[k]) begin
        hits++;
        if (first == 0) begin first = c; got_rd = o_rdata[k]; got_out = o_out[k]; end
        rel = 1'b1;
      end
    end
    t_mr[k] = 1'b0; t_mw[k] = 1'b0;
    if (wr) begin
      if (a < 16'h0100) ref_mem[k][a[7:0]] = wd;
      else if (a == 16'hFFFE) ref_out[k] = wd;
    end else if (rd) begin
      if (a < 16'h0100)       exp_rd = ref_mem[k][a[7:0]];
      else if (a == 16'hFFFE) exp_rd = ref_out[k];
      else if (a == 16'hFFFC) exp_rd = cnt_snap;
      else                    exp_rd = 16'h0000;
      ref_rd[k] = exp_rd;
    end
    chk({tag, " latency"}, 32'(first), 32'(2 + ws));
    chk({tag, " pulses"}, 32'(hits), 32'd1);
    chk({tag, " readdata"}, 32'(got_rd), 32'(ref_rd[k]));
    chk({tag, " out_port"}, 32'(got_out), 32'(ref_out[k]));
  endtask

  // Back-to-back loader writes; expects one ld_ready per cycle.
  task automatic ld_burst(input int k, input logic [7:0] aq[$], input logic [15:0] dq[$], input string tag);
    int n_ok;
    n_ok = 0;
    for (int i = 0; i < aq.size(); i++) begin
      @(negedge clk);
      if (i > 0 && o_ldr[k]) n_ok++;
      t_ldv[k] = 1'b1; t_lda[k] = aq[i]; t_ldd[k] = dq[i];
      ref_mem[k][aq[i]] = dq[i];
    end
    @(negedge clk);
    if (o_ldr[k]) n_ok++;
    t_ldv[k] = 1'b0;
    @(negedge clk);
    chk({tag, " accepts"}, 32'(n_ok), 32'(aq.size()));
    chk({tag, " ld_ready idle"}, 32'(o_ldr[k]), 32'd0);
  endtask

  initial begin
    logic [7:0]  aq[$];
    logic [15:0] dq[$];
    logic [15:0] g_rd, g_out, a, d;
    int          rdy_c, ldr_c, hits, op;
    logic        rel;

    checks = 0; errors = 0;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t_adr[k] = '0; t_wd[k] = '0; t_mr[k] = 1'b0; t_mw[k] = 1'b0;
      t_ldv[k] = 1'b0; t_lda[k] = '0; t_ldd[k] = '0;
      ref_out[k] = '0; ref_rd[k] = '0;
    end

    tbl[0]  = '{1'b1, 1'b0, 16'h0006, 16'h0000, 16'hBEEF, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 16'hFFFE, 16'h00AA, 16'hBEEF, 16'h00AA};
    tbl[2]  = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h00AA, 16'h00AA};
    tbl[3]  = '{1'b0, 1'b1, 16'h4005, 16'h5555, 16'h00AA, 16'h00AA};
    tbl[4]  = '{1'b1, 1'b0, 16'h4005, 16'h0000, 16'h0000, 16'h00AA};
    tbl[5]  = '{1'b1, 1'b1, 16'h0010, 16'hC0DE, 16'h0000, 16'h00AA};
    tbl[6]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hC0DE, 16'h00AA};
    tbl[7]  = '{1'b0, 1'b1, 16'hFFFC, 16'h1111, 16'hC0DE, 16'h00AA};
    tbl[8]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 16'h00AA};
    tbl[9]  = '{1'b0, 1'b1, 16'h00FF, 16'h7E57, 16'h1234, 16'h00AA};
    tbl[10] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h7E57, 16'h00AA};
    tbl[11] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h00AA};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d ready", k), 32'(o_ready[k]), 32'd0);
      chk($sformatf("rst%0d ld_ready", k), 32'(o_ldr[k]), 32'd0);
      chk($sformatf("rst%0d readdata", k), 32'(o_rdata[k]), 32'd0);
      chk($sformatf("rst%0d out_port", k), 32'(o_out[k]), 32'd0);
    end
    reset = 1'b1;

    // Fill every RAM word so the model knows all contents
    for (int k = 0; k < 2; k++) begin
      aq = {}; dq = {};
      for (int i = 0; i < 256; i++) begin aq.push_back(8'(i)); dq.push_back(16'($urandom)); end
      ld_burst(k, aq, dq, $sformatf("fill%0d", k));
      aq = {8'h05, 8'h06}; dq = {16'h1234, 16'hBEEF};
      ld_burst(k, aq, dq, $sformatf("ld0506_%0d", k));
    end

    // One wait state: ready at the third sampled cycle only
    core_txn(0, 1'b1, 1'b0, 16'h0005, 16'h0000, "ws1 rd05", 1'b0, g_rd, g_out);
    chk("ws1 rd05 value", 32'(g_rd), 32'h1234);
    core_txn(0, 1'b1, 1'b0, 16'h0006, 16'h0000, "ws1 rd06", 1'b0, g_rd, g_out);
    chk("ws1 rd06 value", 32'(g_rd), 32'hBEEF);

    // Core read and loader write raised together
    @(negedge clk);
    t_adr[0] = 16'h0006; t_mr[0] = 1'b1;
    t_ldv[0] = 1'b1; t_lda[0] = 8'h20; t_ldd[0] = 16'h0A5A;
    rdy_c = 0; ldr_c = 0; rel = 1'b0; g_rd = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rel) begin t_mr[0] = 1'b0; rel = 1'b0; end
      if (o_ready[0] && rdy_c == 0) begin rdy_c = c; g_rd = o_rdata[0]; rel = 1'b1; end
      if (o_ldr[0] && ldr_c == 0) begin ldr_c = c; t_ldv[0] = 1'b0; end
    end
    t_mr[0] = 1'b0; t_ldv[0] = 1'b0;
    ref_mem[0][8'h20] = 16'h0A5A;
    ref_rd[0] = ref_mem[0][8'h06];
    chk("coll ready cycle", 32'(rdy_c), 32'd3);
    chk("coll readdata", 32'(g_rd), 32'hBEEF);
    chk("coll loader after core", 32'(ldr_c > rdy_c), 32'd1);
    core_txn(0, 1'b1, 1'b0, 16'h0020, 16'h0000, "coll rd20", 1'b0, g_rd, g_out);

    // Directed vectors on the zero-wait-state responder
    for (int i = 0; i < 12; i++) begin
      core_txn(1, tbl[i].rd, tbl[i].wr, tbl[i].adr, tbl[i].wd, $sformatf("tbl%0d", i), 1'b0, g_rd, g_out);
      chk($sformatf("tbl%0d const rd", i), 32'(g_rd), 32'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d const out", i), 32'(g_out), 32'(tbl[i].exp_out));
    end
    core_txn(1, 1'b1, 1'b0, 16'hFFFC, 16'h0000, "cnt rd", 1'b0, g_rd, g_out);
    core_txn(1, 1'b1, 1'b0, 16'h0105, 16'h0000, "unmapped rd", 1'b0, g_rd, g_out);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 2; k++) begin
        op = int'($urandom_range(0, 9));
        if (op < 6)       a = 16'($urandom_range(0, 255));
        else if (op == 6) a = 16'hFFFE;
        else if (op == 7) a = 16'hFFFC;
        else              a = 16'($urandom_range(256, 65531));
        d  = 16'($urandom);
        op = int'($urandom_range(0, 2));
        core_txn(k, op != 1, op != 0, a, d, $sformatf("rnd%0d_%0d", k, i), 1'b0, g_rd, g_out);
        if ($urandom_range(0, 3) == 0) begin
          aq = {8'($urandom)}; dq = {16'($urandom)};
          ld_burst(k, aq, dq, $sformatf("rndld%0d_%0d", k, i));
        end
      end
    end

    // Reset during the wait state of a RAM write
    @(negedge clk);
    t_adr[0] = 16'h0007; t_wd[0] = 16'hDEAD; t_mw[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      t_mw[0] = 1'b0;
      if (o_ready[0]) hits++;
    end
    chk("rst mid ready", 32'(hits), 32'd0);
    chk("rst mid out_port0", 32'(o_out[0]), 32'd0);
    chk("rst mid out_port1", 32'(o_out[1]), 32'd0);
    chk("rst mid readdata0", 32'(o_rdata[0]), 32'd0);
    ref_out[0] = '0; ref_out[1] = '0; ref_rd[0] = '0; ref_rd[1] = '0;
    reset = 1'b1;
    core_txn(0, 1'b1, 1'b0, 16'hFFFC, 16'h0000, "post rst cnt", 1'b1, g_rd, g_out);
    chk("post rst cnt zero", 32'(g_rd), 32'd0);
    core_txn(0, 1'b1, 1'b0, 16'h0007, 16'h0000, "post rst rd07", 1'b0, g_rd, g_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nitc_mem_responder.md
# nitc_mem_responder

Memory-side responder for the NITC-RISC24 multicycle core's memory bus. It serves the core's `adr`/`writedata`/`memwrite` requests, plus an explicit read strobe, with a ready handshake and configurable wait states. It also provides a word-addressed RAM, two memory-mapped registers (output port, cycle counter) and a low-priority program-loader port that fills RAM before or between core accesses.

## Interface
- `ADDR_BITS`, 8: RAM depth is 2^ADDR_BITS 16-bit words; the address is a word address.
- `WAIT_STATES`, 1: number of extra cycles inserted before `ready`, range 0..15.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `adr`  in  16  word address from core.
- `writedata`  in  16  store data from core.
- `memwrite`  in  1  write request, held until `ready`.
- `memread`  in  1  read request, held until `ready`.
- `readdata`  out  16  load data, valid while `ready`=1.
- `ready`  out  1  one-cycle completion pulse.
- `ld_valid`  in  1  loader write request.
- `ld_adr`  in  ADDR_BITS  loader word address.
- `ld_data`  in  16  loader data.
- `ld_ready`  out  1  one-cycle loader-accept pulse.
- `out_port`  out  16  MMIO output register.

## Operation
- Address decode:
  - `adr` < 2^ADDR_BITS maps to RAM.
  - 0xFFFE maps to `out_port` (read/write).
  - 0xFFFC maps to the cycle counter (read-only; writes ignored).
  - Any other address reads 0 and ignores writes, but still completes with `ready`.
- FSM states and transitions:
  - IDLE → WAIT on a core request when WAIT_STATES>0. A core request is `memread` or `memwrite`.
  - IDLE → RESP on a core request when WAIT_STATES=0.
  - WAIT counts down WAIT_STATES cycles, then → RESP.
  - RESP asserts `ready` and always returns to IDLE.
  - IDLE handles a loader write when `ld_valid` is high and no core request is present. It stays in IDLE and pulses `ld_ready`.
- `adr`, `writedata` and the request type are latched on leaving IDLE. Later changes on the inputs are ignored until the next IDLE.
- `memread` and `memwrite` asserted together: treated as a write; `readdata` holds its previous value.
- Core priority: a core request in IDLE always beats `ld_valid`. The loader waits, holding its inputs.
- The core must deassert its request in the cycle after `ready`. A request still high in IDLE starts a new transaction.
- Cycle counter: 16-bit, increments every cycle after reset, wraps 0xFFFF → 0x0000.
- RAM contents are not cleared by reset.

## Timing
- Reset values: `ready`=0, `ld_ready`=0, `readdata`=0, `out_port`=0, counter=0, FSM=IDLE.
- Request first seen high in IDLE at edge N → `ready` high for exactly the cycle after edge N+1+WAIT_STATES.
- Read: `readdata` is registered and valid in the same cycle as `ready`. It holds until the next read completes.
- Write: RAM or `out_port` update at the edge that enters RESP, so the new value is visible to the next transaction.
- Loader: `ld_valid` sampled high in IDLE with no core request at edge N → RAM written at edge N, `ld_ready` high in the following cycle. Back-to-back loader writes complete 1 per cycle.
- Counter read returns the value latched when leaving IDLE.
- Reset low mid-transaction (WAIT/RESP):
  - FSM returns to IDLE with no `ready`.
  - A core write is dropped unless it was already committed at entry to RESP.
  - Reset takes priority over every other event in the same cycle.

## Structure
- Package `nitc_mem_pkg`: FSM state enum (IDLE, WAIT, RESP), MMIO address constants `OUT_PORT_ADR`=16'hFFFE and `CYCLE_CNT_ADR`=16'hFFFC.
- Sub-module `nitc_ram_sp`: single-port synchronous RAM, ADDR_BITS×16, with write enable and registered read. The core path and the loader path share its port through a mux controlled by the FSM.

## Test plan
- Loader writes 0x1234 to 0x05 and 0xBEEF to 0x06 back-to-back → two consecutive `ld_ready` pulses. A later core read of 0x06 returns 0xBEEF.
- WAIT_STATES=1: `memread` with `adr`=0x05 first seen at edge N → `ready` and `readdata`=0x1234 in the cycle after edge N+2, and nowhere else.
- WAIT_STATES=0: `memwrite` 0x00AA to 0xFFFE → `out_port`=0x00AA when `ready` pulses. A following read of 0xFFFE returns 0x00AA. A write to 0xFFFC leaves the counter running.
- `ld_valid` and `memread` asserted in the same IDLE cycle → core served first. `ld_ready` only pulses after the core's `ready`, and the loaded data is correct.
- Read of 0x4000 (unmapped) → `ready` with `readdata`=0. Write to 0x4000 changes no RAM word.
- `reset` low during WAIT of a write to 0x07 → no `ready`, RAM[0x07] unchanged, `out_port`=0, counter=0 after reset.
